// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: buffers DEPTH micro-ops, wakes operands from the CDB and issues the oldest ready entry.
// Optional macro RS_CDB_FWD_EN lets a same-cycle CDB hit count toward eligibility.
module rs_issue_sched #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 64,
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic                 disp_src1_rdy,
    input  logic [TAG_W-1:0]     disp_src2_tag,
    input  logic                 disp_src2_rdy,
    input  logic [TAG_W-1:0]     disp_dst_tag,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [TAG_W-1:0]     issue_src1_tag,
    output logic [TAG_W-1:0]     issue_src2_tag,
    output logic [TAG_W-1:0]     issue_dst_tag,
    output logic [PAYLOAD_W-1:0] issue_payload,
    output logic [OCC_W-1:0]     occupancy
);

    logic [DEPTH-1:0]                  r_valid;
    logic [DEPTH-1:0]                  r_s1_rdy;
    logic [DEPTH-1:0]                  r_s2_rdy;
    logic [DEPTH-1:0][TAG_W-1:0]       r_s1_tag;
    logic [DEPTH-1:0][TAG_W-1:0]       r_s2_tag;
    logic [DEPTH-1:0][TAG_W-1:0]       r_dst;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]   r_pay;
    // r_older[i][j] = 1 when entry j was dispatched before entry i
    logic [DEPTH-1:0][DEPTH-1:0]       r_older;

    logic [DEPTH-1:0] w_s1_hit;
    logic [DEPTH-1:0] w_s2_hit;
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_sel;
    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_alloc;
    logic [DEPTH-1:0] w_live;
    logic [OCC_W-1:0] w_occ;
    logic             w_iss_en;
    logic             w_disp_fire;
    logic             w_d1_hit;
    logic             w_d2_hit;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_s1_hit[i] = cdb_valid && (r_s1_tag[i] == cdb_tag);
            w_s2_hit[i] = cdb_valid && (r_s2_tag[i] == cdb_tag);
        end
    end

`ifdef RS_CDB_FWD_EN
    assign w_elig = r_valid & (r_s1_rdy | w_s1_hit) & (r_s2_rdy | w_s2_hit);
`else
    assign w_elig = r_valid & r_s1_rdy & r_s2_rdy;
`endif

    // The age matrix is a total order over valid entries, so exactly one eligible entry has no older eligible peer
    assign w_iss_en = rstn && !flush;
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_sel[i] = w_iss_en && w_elig[i] && !(|(r_older[i] & w_elig));
    end

    assign issue_valid = |w_sel;
    assign w_free      = w_sel & {DEPTH{issue_ready}};
    assign w_live      = r_valid & ~w_free;

    always_comb begin
        issue_src1_tag = '0;
        issue_src2_tag = '0;
        issue_dst_tag  = '0;
        issue_payload  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                issue_src1_tag = issue_src1_tag | r_s1_tag[i];
                issue_src2_tag = issue_src2_tag | r_s2_tag[i];
                issue_dst_tag  = issue_dst_tag  | r_dst[i];
                issue_payload  = issue_payload  | r_pay[i];
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++)
            w_occ = w_occ + OCC_W'(r_valid[i]);
    end
    assign occupancy = w_occ;

    // Lowest-index free slot: isolate the lowest zero bit of r_valid
    assign w_alloc     = ~r_valid & (r_valid + DEPTH'(1));
    assign disp_ready  = !rstn || (!flush && (w_occ < OCC_W'(DEPTH)));
    assign w_disp_fire = rstn && disp_valid && disp_ready;
    assign w_d1_hit    = cdb_valid && (disp_src1_tag == cdb_tag);
    assign w_d2_hit    = cdb_valid && (disp_src2_tag == cdb_tag);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid  <= '0;
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
            r_older  <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_live | (w_disp_fire ? w_alloc : '0);
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && w_s1_hit[i]) r_s1_rdy[i] <= 1'b1;
                if (r_valid[i] && w_s2_hit[i]) r_s2_rdy[i] <= 1'b1;
                if (w_disp_fire) begin
                    if (w_alloc[i]) begin
                        r_s1_rdy[i] <= disp_src1_rdy || w_d1_hit;
                        r_s2_rdy[i] <= disp_src2_rdy || w_d2_hit;
                        r_older[i]  <= w_live;
                    end else begin
                        r_older[i]  <= r_older[i] & ~w_alloc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && w_alloc[i]) begin
                r_s1_tag[i] <= disp_src1_tag;
                r_s2_tag[i] <= disp_src2_tag;
                r_dst[i]    <= disp_dst_tag;
                r_pay[i]    <= disp_payload;
            end
        end
    end

endmodule
